stage_merge_pipe: RTL and testbench

Parametrised merge-and-retime layer between a stage's NUM_SUB_UNIT match sub-units and its action engine. Combines per-sub-unit action vectors into one action word, selectable as OR-merge or priority, and flags multi-hit and miss. Carries PHV and VLAN alongside the merged action through a 2-entry skid buffer with full valid/ready back-pressure, so a stalled action engine never drops a lookup result.

---
 rtl/stage_pkg.sv | 21 ++
 rtl/stage_merge_pipe_if.sv | 48 ++++
 rtl/stage_merge_pipe_action_merge_comb.sv | 44 ++++
 rtl/stage_merge_pipe.sv | 158 +++++++++++++++
 tb/tb_stage_merge_pipe.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_pkg.sv
// Shared constants for the match stage: merge-mode selectors, default
// widths and the skid-buffer occupancy state type.
package stage_pkg;

    localparam int MERGE_OR   = 0;
    localparam int MERGE_PRIO = 1;

    localparam int DEF_NUM_SUB_UNIT   = 8;
    localparam int DEF_ACT_W          = 64 * 65;
    localparam int DEF_PHV_LEN        = 32 * 64 + 256;
    localparam int DEF_C_VLANID_WIDTH = 12;
    localparam int DEF_CNT_W          = 32;

    // Occupancy of the 2-entry skid buffer; the encoding equals the entry count.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/stage_merge_pipe_if.sv
// Bundle between the match sub-units (upstream) and the action engine
// (downstream) of one stage.
//
// Handshake: an upstream beat transfers on a rising edge where
// phv_valid_in && ready_out; a downstream beat transfers where
// valid_out && ready_in. ready_out never depends on ready_in in the same
// cycle, and downstream outputs hold steady while valid_out && !ready_in.
interface stage_merge_pipe_if
    import stage_pkg::*;
#(
    parameter int NUM_SUB_UNIT   = DEF_NUM_SUB_UNIT,
    parameter int ACT_W          = DEF_ACT_W,
    parameter int PHV_LEN        = DEF_PHV_LEN,
    parameter int C_VLANID_WIDTH = DEF_C_VLANID_WIDTH
) ();

    logic [PHV_LEN-1:0]            phv_in;
    logic [C_VLANID_WIDTH-1:0]     vlan_in;
    logic                          phv_valid_in;
    logic [NUM_SUB_UNIT*ACT_W-1:0] act_in;
    logic [NUM_SUB_UNIT-1:0]       act_hit_in;
    logic                          ready_out;

    logic [PHV_LEN-1:0]            phv_out;
    logic [C_VLANID_WIDTH-1:0]     vlan_out;
    logic [ACT_W-1:0]              act_out;
    logic [NUM_SUB_UNIT-1:0]       hit_vec_out;
    logic                          multi_hit_out;
    logic                          miss_out;
    logic                          valid_out;
    logic                          ready_in;

    // Debug view of the buffer occupancy state.
    buf_state_e                    buf_state;

    modport slave (
        input  phv_in, vlan_in, phv_valid_in, act_in, act_hit_in, ready_in,
        output ready_out, phv_out, vlan_out, act_out, hit_vec_out,
               multi_hit_out, miss_out, valid_out, buf_state
    );

    modport master (
        output phv_in, vlan_in, phv_valid_in, act_in, act_hit_in, ready_in,
        input  ready_out, phv_out, vlan_out, act_out, hit_vec_out,
               multi_hit_out, miss_out, valid_out, buf_state
    );

endinterface

// File: rtl/stage_merge_pipe_action_merge_comb.sv
// Combinational merge of per-sub-unit action vectors into one action word.
// Non-hitting slices never contribute; MERGE_OR ORs all hitting slices,
// MERGE_PRIO takes the slice of the lowest-index hit.
module action_merge_comb
    import stage_pkg::*;
#(
    parameter int NUM_SUB_UNIT = DEF_NUM_SUB_UNIT,
    parameter int ACT_W        = DEF_ACT_W,
    parameter int MERGE_MODE   = MERGE_OR
) (
    input  logic [NUM_SUB_UNIT*ACT_W-1:0] act_in,
    input  logic [NUM_SUB_UNIT-1:0]       hit_in,
    output logic [ACT_W-1:0]              act_out,
    output logic                          multi_hit_out,
    output logic                          miss_out
);

    logic hit_seen;

    // Walk the units from index 0 upward so the first hit seen is the priority winner.
    always_comb begin
        act_out  = '0;
        hit_seen = 1'b0;
        for (int i = 0; i < NUM_SUB_UNIT; i++) begin
            if (hit_in[i]) begin
                if (MERGE_MODE == MERGE_PRIO) begin
                    if (!hit_seen) begin
                        act_out = act_in[i*ACT_W +: ACT_W];
                    end
                end else begin
                    act_out = act_out | act_in[i*ACT_W +: ACT_W];
                end
                hit_seen = 1'b1;
            end
        end
    end

    // Hit-count flags; a miss leaves act_out at zero from the loop above.
    always_comb begin
        multi_hit_out = ($countones(hit_in) > 1);
        miss_out      = (hit_in == '0);
    end

endmodule

// File: rtl/stage_merge_pipe.sv
// Merge-and-retime layer between a stage's match sub-units and its action
// engine: merged action, PHV and VLAN travel together through a 2-entry
// skid buffer (head drives outputs, tail is the skid slot).
// Optional per-unit hit counters: define STAGE_MERGE_HIT_CNT_EN.
module stage_merge_pipe
    import stage_pkg::*;
#(
    parameter int NUM_SUB_UNIT   = DEF_NUM_SUB_UNIT,
    parameter int ACT_W          = DEF_ACT_W,
    parameter int PHV_LEN        = DEF_PHV_LEN,
    parameter int C_VLANID_WIDTH = DEF_C_VLANID_WIDTH,
    parameter int MERGE_MODE     = MERGE_OR
`ifdef STAGE_MERGE_HIT_CNT_EN
    ,
    parameter int CNT_W          = DEF_CNT_W
`endif
) (
    input  logic                    axis_clk,
    input  logic                    aresetn,
    stage_merge_pipe_if.slave       bus
`ifdef STAGE_MERGE_HIT_CNT_EN
    ,
    output logic [NUM_SUB_UNIT*CNT_W-1:0] hit_cnt_out,
    output logic [CNT_W-1:0]              multi_hit_cnt_out,
    input  logic                          cnt_clr
`endif
);

    localparam int ENT_W = PHV_LEN + C_VLANID_WIDTH + ACT_W + NUM_SUB_UNIT + 2;

    logic [ACT_W-1:0] merged_act;
    logic             merged_multi;
    logic             merged_miss;
    logic [ENT_W-1:0] new_ent;
    logic [ENT_W-1:0] head_q, head_d;
    logic [ENT_W-1:0] tail_q, tail_d;
    buf_state_e       state_q, state_d;
    logic             ready_int;
    logic             valid_int;
    logic             push;
    logic             pop;

    action_merge_comb #(
        .NUM_SUB_UNIT (NUM_SUB_UNIT),
        .ACT_W        (ACT_W),
        .MERGE_MODE   (MERGE_MODE)
    ) u_merge (
        .act_in        (bus.act_in),
        .hit_in        (bus.act_hit_in),
        .act_out       (merged_act),
        .multi_hit_out (merged_multi),
        .miss_out      (merged_miss)
    );

    assign new_ent = {bus.phv_in, bus.vlan_in, merged_act, bus.act_hit_in,
                      merged_multi, merged_miss};
    assign push    = bus.phv_valid_in && ready_int;
    assign pop     = valid_int && bus.ready_in;

    // State register plus entry storage; reset empties the buffer and zeroes the head.
    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Next occupancy from push/pop; push and pop at FULL cannot coincide.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BUF_EMPTY: if (push) state_d = BUF_ONE;
            BUF_ONE: begin
                if (push && !pop)      state_d = BUF_FULL;
                else if (!push && pop) state_d = BUF_EMPTY;
            end
            BUF_FULL:  if (pop) state_d = BUF_ONE;
            default:   state_d = BUF_EMPTY;
        endcase
    end

    // Entry movement: fill head first, skid into tail, promote tail on pop.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        unique case (state_q)
            BUF_EMPTY: if (push) head_d = new_ent;
            BUF_ONE: begin
                if (push && pop) head_d = new_ent;
                else if (push)   tail_d = new_ent;
            end
            BUF_FULL:  if (pop) head_d = tail_q;
            default: ;
        endcase
    end

    // Handshake outputs decoded from the registered state only.
    always_comb begin
        ready_int = (state_q != BUF_FULL);
        valid_int = (state_q != BUF_EMPTY);
    end

    assign bus.ready_out = ready_int;
    assign bus.valid_out = valid_int;
    assign bus.buf_state = state_q;
    assign {bus.phv_out, bus.vlan_out, bus.act_out, bus.hit_vec_out,
            bus.multi_hit_out, bus.miss_out} = head_q;

`ifdef STAGE_MERGE_HIT_CNT_EN
    logic [NUM_SUB_UNIT-1:0][CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]                   multi_cnt_q, multi_cnt_d;

    // Counter registers.
    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            hit_cnt_q   <= '0;
            multi_cnt_q <= '0;
        end else begin
            hit_cnt_q   <= hit_cnt_d;
            multi_cnt_q <= multi_cnt_d;
        end
    end

    // Saturating increment on accepted pushes; clear wins over increment.
    always_comb begin
        hit_cnt_d   = hit_cnt_q;
        multi_cnt_d = multi_cnt_q;
        if (cnt_clr) begin
            hit_cnt_d   = '0;
            multi_cnt_d = '0;
        end else if (push) begin
            for (int i = 0; i < NUM_SUB_UNIT; i++) begin
                if (bus.act_hit_in[i] && (hit_cnt_q[i] != {CNT_W{1'b1}})) begin
                    hit_cnt_d[i] = hit_cnt_q[i] + CNT_W'(1);
                end
            end
            if (merged_multi && (multi_cnt_q != {CNT_W{1'b1}})) begin
                multi_cnt_d = multi_cnt_q + CNT_W'(1);
            end
        end
    end

    // Flatten the per-unit counters onto the output bus.
    always_comb begin
        hit_cnt_out = '0;
        for (int i = 0; i < NUM_SUB_UNIT; i++) begin
            hit_cnt_out[i*CNT_W +: CNT_W] = hit_cnt_q[i];
        end
        multi_hit_cnt_out = multi_cnt_q;
    end
`endif

endmodule

// File: tb/tb_stage_merge_pipe.sv
// Bench for stage_merge_pipe: one OR-merge and one priority-merge instance
// driven with identical stimulus and compared against a queue-based model.
module tb_stage_merge_pipe;
    import stage_pkg::*;

    localparam int NSU = 8;
    localparam int AW  = 20;
    localparam int PL  = 40;
    localparam int VW  = 12;
`ifdef STAGE_MERGE_HIT_CNT_EN
    localparam int CW  = 4;
`endif

    typedef struct packed {
        logic [PL-1:0]  phv;
        logic [VW-1:0]  vlan;
        logic [AW-1:0]  act;
        logic [NSU-1:0] hit;
        logic           multi;
        logic           miss;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus variables ----------------
    logic [PL-1:0]      phv_d;
    logic [VW-1:0]      vlan_d;
    logic               pv;
    logic [NSU*AW-1:0]  act_d;
    logic [NSU-1:0]     hit_d;
    logic               rdy;

    stage_merge_pipe_if #(.NUM_SUB_UNIT(NSU), .ACT_W(AW), .PHV_LEN(PL), .C_VLANID_WIDTH(VW)) if0 ();
    stage_merge_pipe_if #(.NUM_SUB_UNIT(NSU), .ACT_W(AW), .PHV_LEN(PL), .C_VLANID_WIDTH(VW)) if1 ();

    assign if0.phv_in = phv_d;  assign if1.phv_in = phv_d;
    assign if0.vlan_in = vlan_d; assign if1.vlan_in = vlan_d;
    assign if0.phv_valid_in = pv; assign if1.phv_valid_in = pv;
    assign if0.act_in = act_d;  assign if1.act_in = act_d;
    assign if0.act_hit_in = hit_d; assign if1.act_hit_in = hit_d;
    assign if0.ready_in = rdy;  assign if1.ready_in = rdy;

`ifdef STAGE_MERGE_HIT_CNT_EN
    logic                cnt_clr;
    logic [NSU*CW-1:0]   hc0, hc1;
    logic [CW-1:0]       mc0, mc1;
    int                  cnt_m[NSU];
    int                  mcnt_m;
`endif

    stage_merge_pipe #(
        .NUM_SUB_UNIT(NSU), .ACT_W(AW), .PHV_LEN(PL), .C_VLANID_WIDTH(VW), .MERGE_MODE(MERGE_OR)
`ifdef STAGE_MERGE_HIT_CNT_EN
        , .CNT_W(CW)
`endif
    ) u_or (
        .axis_clk (clk),
        .aresetn  (rst_n),
        .bus      (if0)
`ifdef STAGE_MERGE_HIT_CNT_EN
        , .hit_cnt_out(hc0), .multi_hit_cnt_out(mc0), .cnt_clr(cnt_clr)
`endif
    );

    stage_merge_pipe #(
        .NUM_SUB_UNIT(NSU), .ACT_W(AW), .PHV_LEN(PL), .C_VLANID_WIDTH(VW), .MERGE_MODE(MERGE_PRIO)
`ifdef STAGE_MERGE_HIT_CNT_EN
        , .CNT_W(CW)
`endif
    ) u_prio (
        .axis_clk (clk),
        .aresetn  (rst_n),
        .bus      (if1)
`ifdef STAGE_MERGE_HIT_CNT_EN
        , .hit_cnt_out(hc1), .multi_hit_cnt_out(mc1), .cnt_clr(cnt_clr)
`endif
    );

    // ---------------- scoreboard ----------------
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference merge straight from the rules: mask by hit, OR or first hit.
    function automatic exp_t model(input int mode);
        exp_t e;
        int   n;
        e       = '0;
        e.phv   = phv_d;
        e.vlan  = vlan_d;
        e.hit   = hit_d;
        n       = 0;
        for (int i = 0; i < NSU; i++) begin
            if (hit_d[i]) begin
                n++;
                if (mode == 0)   e.act = e.act | act_d[i*AW +: AW];
                else if (n == 1) e.act = act_d[i*AW +: AW];
            end
        end
        e.multi = (n > 1);
        e.miss  = (n == 0);
        return e;
    endfunction

    task automatic check_side(input string nm, input int qs, input exp_t hd,
                              input logic v, input logic r, input exp_t obs);
        chk($sformatf("%s_valid", nm), 64'(v), 64'(qs != 0));
        chk($sformatf("%s_ready", nm), 64'(r), 64'(qs < 2));
        if (qs != 0) begin
            chk($sformatf("%s_phv", nm),   64'(obs.phv),   64'(hd.phv));
            chk($sformatf("%s_vlan", nm),  64'(obs.vlan),  64'(hd.vlan));
            chk($sformatf("%s_act", nm),   64'(obs.act),   64'(hd.act));
            chk($sformatf("%s_hit", nm),   64'(obs.hit),   64'(hd.hit));
            chk($sformatf("%s_multi", nm), 64'(obs.multi), 64'(hd.multi));
            chk($sformatf("%s_miss", nm),  64'(obs.miss),  64'(hd.miss));
        end
    endtask

    task automatic check_all();
        exp_t h0, h1;
        h0 = (exp_q0.size() != 0) ? exp_q0[0] : '0;
        h1 = (exp_q1.size() != 0) ? exp_q1[0] : '0;
        check_side("or", exp_q0.size(), h0, if0.valid_out, if0.ready_out,
                   exp_t'({if0.phv_out, if0.vlan_out, if0.act_out, if0.hit_vec_out,
                           if0.multi_hit_out, if0.miss_out}));
        check_side("prio", exp_q1.size(), h1, if1.valid_out, if1.ready_out,
                   exp_t'({if1.phv_out, if1.vlan_out, if1.act_out, if1.hit_vec_out,
                           if1.multi_hit_out, if1.miss_out}));
`ifdef STAGE_MERGE_HIT_CNT_EN
        for (int i = 0; i < NSU; i++) begin
            chk($sformatf("or_hit_cnt%0d", i),   64'(hc0[i*CW +: CW]), 64'(cnt_m[i]));
            chk($sformatf("prio_hit_cnt%0d", i), 64'(hc1[i*CW +: CW]), 64'(cnt_m[i]));
        end
        chk("or_multi_cnt",   64'(mc0), 64'(mcnt_m));
        chk("prio_multi_cnt", 64'(mc1), 64'(mcnt_m));
`endif
    endtask

    // One clock: check outputs, advance the model with the pre-edge inputs, move to the next negedge.
    task automatic step();
        exp_t e0, e1;
        bit   do_push, do_pop;
        check_all();
        e0 = model(0);
        e1 = model(1);
        if (!rst_n) begin
            exp_q0.delete();
            exp_q1.delete();
`ifdef STAGE_MERGE_HIT_CNT_EN
            foreach (cnt_m[i]) cnt_m[i] = 0;
            mcnt_m = 0;
`endif
        end else begin
            do_pop  = (exp_q0.size() != 0) && rdy;
            do_push = pv && (exp_q0.size() < 2);
            if (do_pop) begin
                void'(exp_q0.pop_front());
                void'(exp_q1.pop_front());
            end
            if (do_push) begin
                exp_q0.push_back(e0);
                exp_q1.push_back(e1);
            end
`ifdef STAGE_MERGE_HIT_CNT_EN
            if (cnt_clr) begin
                foreach (cnt_m[i]) cnt_m[i] = 0;
                mcnt_m = 0;
            end else if (do_push) begin
                foreach (cnt_m[i]) if (hit_d[i] && cnt_m[i] < 15) cnt_m[i]++;
                if (e0.multi && mcnt_m < 15) mcnt_m++;
            end
`endif
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- driver helpers ----------------
    task automatic rand_acts();
        logic [31:0] r;
        for (int i = 0; i < NSU; i++) begin
            r = $urandom;
            act_d[i*AW +: AW] = r[AW-1:0];
        end
    endtask

    task automatic drive(input logic [NSU-1:0] h);
        logic [31:0] r;
        rand_acts();
        r = $urandom;  phv_d[31:0] = r;
        r = $urandom;  phv_d[PL-1:32] = r[PL-33:0];
        r = $urandom;  vlan_d = r[VW-1:0];
        hit_d = h;
        pv    = 1'b1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] r;
        logic [PL-1:0] p_saved;

        rst_n = 1'b0;
        rdy   = 1'b1;
        drive(8'hFF);
`ifdef STAGE_MERGE_HIT_CNT_EN
        cnt_clr = 1'b0;
        foreach (cnt_m[i]) cnt_m[i] = 0;
        mcnt_m = 0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pv    = 1'b0;

        // Reset state: empty, accepting, all data outputs zero.
        chk("rst_valid",  64'(if0.valid_out), 64'(0));
        chk("rst_ready",  64'(if0.ready_out), 64'(1));
        chk("rst_phv",    64'(if0.phv_out),   64'(0));
        chk("rst_vlan",   64'(if0.vlan_out),  64'(0));
        chk("rst_act",    64'(if0.act_out),   64'(0));
        chk("rst_hit",    64'(if0.hit_vec_out), 64'(0));
        chk("rst_multi",  64'(if0.multi_hit_out), 64'(0));
        chk("rst_miss",   64'(if0.miss_out),  64'(0));
        chk("rst_prio_valid", 64'(if1.valid_out), 64'(0));
        chk("rst_prio_ready", 64'(if1.ready_out), 64'(1));

        // Single hit on unit 2 with action 0xAB.
        drive(8'h04);
        act_d[2*AW +: AW] = AW'(32'hAB);
        step();
        chk("t1_valid", 64'(if0.valid_out), 64'(1));
        chk("t1_act",   64'(if0.act_out),   64'(32'hAB));
        chk("t1_hit",   64'(if0.hit_vec_out), 64'(8'h04));
        chk("t1_miss",  64'(if0.miss_out),  64'(0));
        chk("t1_multi", 64'(if0.multi_hit_out), 64'(0));
        chk("t1_prio_act", 64'(if1.act_out), 64'(32'hAB));
        pv = 1'b0;
        step();

        // Units 1 and 5 hit: OR gives 0xFF, priority gives unit 1's 0x0F.
        drive(8'h22);
        act_d[1*AW +: AW] = AW'(32'h0F);
        act_d[5*AW +: AW] = AW'(32'hF0);
        step();
        chk("t2_or_act",    64'(if0.act_out),       64'(32'hFF));
        chk("t2_or_multi",  64'(if0.multi_hit_out), 64'(1));
        chk("t2_prio_act",  64'(if1.act_out),       64'(32'h0F));
        chk("t2_prio_multi", 64'(if1.multi_hit_out), 64'(1));
        pv = 1'b0;
        step();

        // Miss: zero action, PHV still forwarded.
        drive(8'h00);
        p_saved = phv_d;
        step();
        chk("t3_valid", 64'(if0.valid_out), 64'(1));
        chk("t3_act",   64'(if0.act_out),   64'(0));
        chk("t3_miss",  64'(if0.miss_out),  64'(1));
        chk("t3_phv",   64'(if0.phv_out),   64'(p_saved));
        chk("t3_prio_act", 64'(if1.act_out), 64'(0));
        pv = 1'b0;
        step();

        // Back-pressure: three pushes with ready_in low, third is held.
        rdy = 1'b0;
        drive(8'h01); act_d[AW-1:0] = AW'(32'h11);
        step();
        chk("bp_ready_after1", 64'(if0.ready_out), 64'(1));
        drive(8'h01); act_d[AW-1:0] = AW'(32'h22);
        step();
        chk("bp_ready_after2", 64'(if0.ready_out), 64'(0));
        drive(8'h01); act_d[AW-1:0] = AW'(32'h33);
        step();
        chk("bp_hold_act", 64'(if0.act_out), 64'(32'h11));
        step();
        chk("bp_hold_act2", 64'(if0.act_out), 64'(32'h11));
        rdy = 1'b1;
        step();
        chk("bp_out2", 64'(if0.act_out),   64'(32'h22));
        chk("bp_out2_valid", 64'(if0.valid_out), 64'(1));
        step();
        chk("bp_out3", 64'(if0.act_out),   64'(32'h33));
        chk("bp_out3_valid", 64'(if0.valid_out), 64'(1));
        pv = 1'b0;
        step();
        chk("bp_drained", 64'(if0.valid_out), 64'(0));

        // Reset with two entries buffered, inputs active during reset.
        rdy = 1'b0;
        drive(8'h03); step();
        drive(8'h0C); step();
        rst_n = 1'b0;
        drive(8'h10);
        step();
        rst_n = 1'b1;
        pv    = 1'b0;
        chk("mrst_valid", 64'(if0.valid_out), 64'(0));
        chk("mrst_ready", 64'(if0.ready_out), 64'(1));
        chk("mrst_act",   64'(if0.act_out),   64'(0));
        rdy = 1'b1;
        repeat (2) step();

        // Randomized traffic with random back-pressure.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 3);
            case (r)
                0:       drive(8'h00);
                1:       drive(8'(1 << $urandom_range(0, NSU - 1)));
                default: drive(8'($urandom));
            endcase
            pv  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            step();
        end
        pv  = 1'b0;
        rdy = 1'b1;
        repeat (3) step();

`ifdef STAGE_MERGE_HIT_CNT_EN
        // Saturation at 15 with 4-bit counters, then clear racing a push.
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        for (int n = 0; n < 20; n++) begin
            drive(8'h01);
            step();
        end
        chk("cnt_sat", 64'(hc0[CW-1:0]), 64'(15));
        drive(8'h01);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        pv = 1'b0;
        chk("cnt_clr_vs_push", 64'(hc0[CW-1:0]), 64'(0));
        repeat (2) step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
